// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Sequences an intersection between day, night, pedestrian and emergency modes.
// Every mode change passes through an all-red CLEAR interval whose registered
// target is chosen by priority arbitration (emergency > pedestrian > day/night)
// and may be re-chosen while clearance runs.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous active-high reset
//   tick         one-cycle 1 Hz enable; all dwell counting is in ticks
//   night        1 = night-time, 0 = day-time (level)
//   ped_req      pedestrian button (pulse or level)
//   emg_req      emergency request (level, held while the vehicle is present)
//   emg_lane     one-hot lane requested by the emergency
//   mode_onehot  0001 day, 0010 night, 0100 ped, 1000 emg, 0000 in clearance
//   clear_active high while in CLEAR (all-red)
//   load_en      one-cycle timer load strobe on the first cycle of each state
//   load_val     timer load value for the current state, held between strobes
//   ped_pending  pedestrian request latched and not yet served
//   emg_lane_q   captured emergency lane, 0 outside an emergency
//
// Optional feature (macro PED_MIN_GAP_EN): enforces PED_GAP vehicle ticks
// between pedestrian phases. Without the macro there is no gap logic.
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int MIN_HOLD   = 10,
  parameter int PED_TIME   = 20,
  parameter int CLR_TIME   = 3,
  parameter int DAY_TIME   = 60,
  parameter int NIGHT_TIME = 30,
  parameter int EMG_TIME   = 127
`ifdef PED_MIN_GAP_EN
  ,
  parameter int PED_GAP    = 30
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       night,
  input  logic       ped_req,
  input  logic       emg_req,
  input  logic [7:0] emg_lane,
  output logic [3:0] mode_onehot,
  output logic       clear_active,
  output logic       load_en,
  output logic [6:0] load_val,
  output logic       ped_pending,
  output logic [7:0] emg_lane_q
);

  typedef enum logic [2:0] {
    DAY   = 3'd0,
    NIGHT = 3'd1,
    PED   = 3'd2,
    EMG   = 3'd3,
    CLEAR = 3'd4
  } phaseT;

  localparam logic [6:0] MIN_HOLD_V = 7'(MIN_HOLD);
  localparam logic [6:0] PED_TIME_V = 7'(PED_TIME);
  localparam logic [6:0] CLR_TIME_V = 7'(CLR_TIME);
  localparam logic [6:0] SAT_MAX    = 7'd127;

  phaseT      state;
  phaseT      stateNext;
  phaseT      target;
  phaseT      targetNext;
  phaseT      dayNight;
  phaseT      emgExitTarget;
  logic [6:0] elapsed;
  logic       pendingNext;
  logic       stateChange;
  logic       gapOk;

  function automatic logic [3:0] modeOf(input phaseT p);
    case (p)
      DAY:     return 4'b0001;
      NIGHT:   return 4'b0010;
      PED:     return 4'b0100;
      EMG:     return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] loadValueOf(input phaseT p);
    case (p)
      DAY:     return 7'(DAY_TIME);
      NIGHT:   return 7'(NIGHT_TIME);
      PED:     return 7'(PED_TIME);
      EMG:     return 7'(EMG_TIME);
      default: return 7'(CLR_TIME);
    endcase
  endfunction

`ifdef PED_MIN_GAP_EN
  // Vehicle ticks since the last pedestrian phase ended. Starts saturated so
  // the first request after reset is not held back.
  logic [6:0] gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap <= SAT_MAX;
    end else if (state == PED && stateNext != PED) begin
      gap <= '0;
    end else if (tick && (state == DAY || state == NIGHT || state == EMG) &&
                 gap != SAT_MAX) begin
      gap <= gap + 7'd1;
    end
  end

  assign gapOk = (gap >= 7'(PED_GAP));
`else
  assign gapOk = 1'b1;
`endif

  assign dayNight      = night ? NIGHT : DAY;
  // Where to go when an emergency ends (or is withdrawn during clearance).
  assign emgExitTarget = (ped_pending && gapOk) ? PED : dayNight;
  assign stateChange   = (stateNext != state);

  // Next-state and target arbitration.
  always_comb begin
    // NOTE: every variable of this block gets a default before the case, so
    // no branch can leave it unassigned and no latch is inferred.
    stateNext  = state;
    targetNext = target;
    case (state)
      DAY, NIGHT: begin
        if (emg_req) begin
          stateNext  = CLEAR;
          targetNext = EMG;
        end else if (ped_pending && gapOk && elapsed >= MIN_HOLD_V) begin
          stateNext  = CLEAR;
          targetNext = PED;
        end else if ((night != (state == NIGHT)) && elapsed >= MIN_HOLD_V) begin
          stateNext  = CLEAR;
          targetNext = dayNight;
        end
      end
      PED: begin
        if (emg_req) begin
          stateNext  = CLEAR;
          targetNext = EMG;
        end else if (elapsed == PED_TIME_V) begin
          stateNext  = CLEAR;
          targetNext = dayNight;
        end
      end
      EMG: begin
        if (!emg_req) begin
          stateNext  = CLEAR;
          targetNext = emgExitTarget;
        end
      end
      CLEAR: begin
        // Retargeting keeps elapsed running: clearance is never lengthened.
        if (emg_req && target != EMG) begin
          targetNext = EMG;
        end else if (!emg_req && target == EMG) begin
          targetNext = emgExitTarget;
        end
        if (elapsed == CLR_TIME_V) begin
          stateNext = targetNext;
        end
      end
      default: begin
        stateNext  = CLEAR;
        targetNext = dayNight;
      end
    endcase
  end

  // Entering PED serves the request; a press in that same cycle is dropped.
  always_comb begin
    pendingNext = ped_pending;
    if (stateNext == PED && state != PED) begin
      pendingNext = 1'b0;
    end else if (ped_req && state != PED) begin
      pendingNext = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and is
    // sampled like any other input.
    if (rst) begin
      state  <= CLEAR;
      target <= dayNight;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop in the
      // design sees pre-edge values regardless of statement order.
      state  <= stateNext;
      target <= targetNext;
    end
  end

  // Dwell counter, registered outputs and lane capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed      <= '0;
      mode_onehot  <= 4'b0000;
      clear_active <= 1'b1;
      load_en      <= 1'b0;
      load_val     <= '0;
      ped_pending  <= 1'b0;
      emg_lane_q   <= '0;
    end else begin
      ped_pending  <= pendingNext;
      load_en      <= stateChange;
      mode_onehot  <= modeOf(stateNext);
      clear_active <= (stateNext == CLEAR);

      if (stateChange) begin
        elapsed  <= '0;
        load_val <= loadValueOf(stateNext);
      end else if (tick && elapsed != SAT_MAX) begin
        elapsed <= elapsed + 7'd1;
      end

      // Lane is sampled once when the emergency is first targeted and held
      // through clearance and EMG; dropping the EMG target clears it.
      if (targetNext != EMG) begin
        emg_lane_q <= '0;
      end else if (target != EMG) begin
        emg_lane_q <= emg_lane;
      end
    end
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences the intersection between four traffic modes: day, night, pedestrian and emergency.
- Inserts an all-red clearance interval between every mode change.
- Drives the one-hot mode select for the light/load-time muxes and a load strobe for the master countdown timer.
- Replaces the free-running mode FSM: adds priority arbitration, minimum dwell, pedestrian request latching and emergency lane capture.

Parameters:
- MIN_HOLD, 10, ticks a day/night mode must dwell before a pedestrian or day/night change may take it over.
- PED_TIME, 20, ticks of pedestrian phase.
- CLR_TIME, 3, ticks of all-red clearance.
- DAY_TIME, 60, timer load value on day entry.
- NIGHT_TIME, 30, timer load value on night entry.
- EMG_TIME, 127, timer load value on emergency entry.
- PED_GAP, 30, minimum vehicle ticks between pedestrian phases (used only with the optional feature).

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle 1 Hz enable; all dwell counting is in ticks.
- night  in  1  1 = night-time, 0 = day-time (level).
- ped_req  in  1  pedestrian button (pulse or level).
- emg_req  in  1  emergency request (level, held while the vehicle is present).
- emg_lane  in  8  one-hot lane requested by the emergency.
- mode_onehot  out  4  0001 day, 0010 night, 0100 ped, 1000 emg; 0000 during clearance.
- clear_active  out  1  high in CLEAR (all-red).
- load_en  out  1  one-cycle timer load strobe.
- load_val  out  7  timer load value, valid with load_en.
- ped_pending  out  1  a pedestrian request is latched and not yet served.
- emg_lane_q  out  8  captured emergency lane; 0 outside EMG.

Behaviour:
- States: DAY, NIGHT, PED, EMG, CLEAR. A registered target (DAY/NIGHT/PED/EMG) is used in CLEAR.
- elapsed: 7-bit counter, cleared on every state entry, +1 per tick, saturates at 127.
- Reset: state = CLEAR, target = DAY if night = 0 else NIGHT, elapsed = 0.
  - Outputs after reset: mode_onehot = 0000, clear_active = 1, load_en = 0, load_val = 0, ped_pending = 0, emg_lane_q = 0.
  - Reset mid-operation aborts any phase with the same values.
- ped_pending:
  - Set on any cycle with ped_req = 1 while state != PED.
  - Cleared in the cycle PED is entered; a ped_req in that same cycle is dropped.
  - ped_req during PED is ignored.
- DAY/NIGHT, priority order, evaluated every cycle:
  - emg_req → CLEAR, target EMG, immediately with no dwell check.
  - else ped_pending and elapsed ≥ MIN_HOLD → CLEAR, target PED.
  - else night disagrees with the current state and elapsed ≥ MIN_HOLD → CLEAR, target NIGHT/DAY.
- PED:
  - emg_req → CLEAR, target EMG.
  - else elapsed == PED_TIME → CLEAR, target per night.
- EMG:
  - Stays while emg_req = 1.
  - On emg_req = 0 → CLEAR, target PED if ped_pending, else per night.
- CLEAR:
  - Exit to target when elapsed == CLR_TIME.
  - emg_req rising in CLEAR retargets to EMG without restarting elapsed.
  - If target is EMG and emg_req drops before exit, retarget per the EMG exit rule.
- emg_lane_q:
  - Captured from emg_lane on the cycle target becomes EMG.
  - Held through CLEAR and EMG; lane changes are ignored until EMG exits.
  - Cleared to 0 on EMG exit.
  - If emg_lane is 0 at capture, EMG still runs; downstream shows all-red.
- Load strobe:
  - load_en = 1 for exactly the first cycle of each state.
  - load_val = DAY_TIME / NIGHT_TIME / PED_TIME / EMG_TIME / CLR_TIME for DAY / NIGHT / PED / EMG / CLEAR.
  - load_val holds its value between strobes.
- mode_onehot and clear_active are registered: they change in the same cycle as the state.
- A state change takes 1 cycle from the deciding input.

Optional Feature:
- Macro: PED_MIN_GAP_EN.
- Defined:
  - A gap counter clears on PED exit and counts ticks only in DAY/NIGHT/EMG, saturating at 127.
  - The DAY/NIGHT→PED rule additionally requires gap ≥ PED_GAP.
  - ped_pending still latches while the gap runs; the EMG exit rule also requires the gap, otherwise target per night.
  - Gap counter resets to 127 so the first request is not delayed.
- Undefined: no gap logic, PED_GAP unused, behaviour exactly as above.

Test Plan:
- Reset with night = 0, 3 ticks:
  - mode_onehot = 0000 and clear_active = 1 through the ticks.
  - Then DAY (0001), load_en with load_val = 60.
- In DAY, ped_req pulse at elapsed = 2:
  - ped_pending = 1.
  - At elapsed = 10 → CLEAR for 3 ticks, then PED (0100) with load_val = 20 and ped_pending = 0.
  - After 20 ticks → CLEAR → DAY.
- In PED at elapsed = 5, emg_req = 1 with emg_lane = 0x04:
  - Next cycle CLEAR with emg_lane_q = 0x04, then EMG (1000).
  - Hold emg_req 50 ticks: EMG holds.
  - emg_req = 0 → CLEAR → DAY.
- In DAY at elapsed = 4, night → 1: no change until elapsed = 10, then CLEAR → NIGHT with load_val = 30.
- In CLEAR with target PED, emg_req = 1 at clear elapsed = 1:
  - Target becomes EMG; exit at elapsed = 3 into EMG.
  - ped_pending stays 1; after EMG ends, CLEAR → PED.
- PED_MIN_GAP_EN defined:
  - ped_req 12 ticks after PED ends: PED is entered only when gap = 30.
  - Undefined: PED entered at MIN_HOLD.
